// File: rtl/palette_pkg.sv
// Shared palette types and default widths for the palette lookup path.
package palette_pkg;

  localparam int PAL_IDX_W = 4;
  localparam int PAL_COL_W = 4;

  typedef logic [PAL_IDX_W-1:0] pal_idx_t;

  typedef struct packed {
    logic [PAL_COL_W-1:0] red;
    logic [PAL_COL_W-1:0] green;
    logic [PAL_COL_W-1:0] blue;
  } rgb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last grant.
// With PAL_ARB_FIXED_PRIO_EN defined, the lowest requesting index wins instead.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    int k;
    k      = 0;
    gnt    = '0;
    gnt_id = '0;
`ifdef PAL_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) gnt_id = ID_W'(i);
    end
`else
    // Scan from the farthest offset down to the nearest, so the last hit is the winner.
    for (int i = N; i >= 1; i--) begin
      k = (int'(last) + i) % N;
      if (req[k]) gnt_id = ID_W'(k);
    end
`endif
    if (en && (|req)) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/palette_lookup_arb.sv
// Arbitrates NREQ pixel requesters onto one combinational palette port through a
// two-stage pipeline. PAL_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module palette_lookup_arb
  import palette_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = PAL_IDX_W,
  parameter int COL_W = PAL_COL_W,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IDX_W-1:0] req_index,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  pal_lock,
  output logic [IDX_W-1:0]      pal_index,
  input  logic [COL_W-1:0]      pal_red,
  input  logic [COL_W-1:0]      pal_green,
  input  logic [COL_W-1:0]      pal_blue,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [3*COL_W-1:0]    rsp_rgb,
  input  logic                  rsp_ready,
  output logic                  busy
);

  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic [IDX_W-1:0] s1_index;
  logic [ID_W-1:0]  last;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             advance;
  logic             accept;
  logic             grant;

  assign advance = !rsp_valid || rsp_ready;
  // Holding reset also keeps req_ready low while requesters are already valid.
  assign accept  = (!s1_valid || advance) && !pal_lock && reset_n;
  assign grant   = |gnt;

  rr_arbiter #(.N(NREQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .last   (last),
    .en     (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign pal_index = s1_index;
  assign busy      = s1_valid | rsp_valid;

`ifdef PAL_ARB_FIXED_PRIO_EN
  assign last = '0;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last <= ID_W'(NREQ - 1);
    else if (grant) last <= gnt_id;
  end
`endif

  // NOTE: non-blocking assignments for all state, so each stage reads pre-edge values of the other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data registers are reset as well, so pal_index/rsp_* read 0 out of reset.
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_index <= '0;
    end else if (grant) begin
      s1_valid <= 1'b1;
      s1_id    <= gnt_id;
      s1_index <= req_index[int'(gnt_id)*IDX_W +: IDX_W];
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rgb   <= '0;
    end else if (advance) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id  <= s1_id;
        rsp_rgb <= {pal_red, pal_green, pal_blue};
      end
    end
  end

endmodule

// File: tb/tb_palette_lookup_arb.sv
// Directed bench for palette_lookup_arb; responses are checked by a queue-based scoreboard.
module tb_palette_lookup_arb;
  import palette_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDX_W = 4;
  localparam int COL_W = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*IDX_W-1:0] req_index;
  logic [NREQ-1:0]       req_ready;
  logic                  pal_lock;
  logic [IDX_W-1:0]      pal_index;
  logic [COL_W-1:0]      pal_red, pal_green, pal_blue;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [3*COL_W-1:0]    rsp_rgb;
  logic                  rsp_ready;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ID_W+3*COL_W-1:0] exp_q[$];
  logic [ID_W+3*COL_W-1:0] exp_e;
  rgb_t pal_rgb;

  always #5 clk = ~clk;

  palette_lookup_arb #(.NREQ(NREQ), .IDX_W(IDX_W), .COL_W(COL_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_index (req_index),
    .req_ready (req_ready),
    .pal_lock  (pal_lock),
    .pal_index (pal_index),
    .pal_red   (pal_red),
    .pal_green (pal_green),
    .pal_blue  (pal_blue),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rgb   (rsp_rgb),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  // Palette stand-in: the entries the tests rely on plus a filler pattern elsewhere.
  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'd5:    return 12'h3CC;
      4'd7:    return 12'h2B3;
      4'd9:    return 12'hB93;
      default: return {idx, ~idx, idx};
    endcase
  endfunction

  assign pal_rgb   = rgb_t'(palette(pal_index));
  assign pal_red   = pal_rgb.red;
  assign pal_green = pal_rgb.green;
  assign pal_blue  = pal_rgb.blue;

  function automatic logic [ID_W-1:0] oh2id(input logic [NREQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) id = ID_W'(i);
    return id;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, check the grant, book the expected response.
  task automatic issue(input logic [NREQ-1:0] v, input logic [3:0] idx, input logic rr,
                       input logic lk, input logic [NREQ-1:0] exp_rdy, input string name);
    req_valid = v;
    req_index = {NREQ{idx}};
    rsp_ready = rr;
    pal_lock  = lk;
    #1;
    check(name, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != '0) exp_q.push_back({oh2id(exp_rdy), palette(idx)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue('0, 4'd0, 1'b1, 1'b0, '0, "idle_ready");
  endtask

  // Monitor: every accepted response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end else begin
        exp_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(exp_e[3*COL_W +: ID_W]));
        check("rsp_rgb", 32'(rsp_rgb), 32'(exp_e[3*COL_W-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] rr_seq[8];
    logic [NREQ-1:0] lock_seq[3];
    logic [NREQ-1:0] pair_seq[4];
`ifdef PAL_ARB_FIXED_PRIO_EN
    rr_seq   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    lock_seq = '{4'b0001, 4'b0001, 4'b0001};
    pair_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
    rr_seq   = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    lock_seq = '{4'b1000, 4'b0001, 4'b1000};
    pair_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`endif

    // Reset with every requester valid.
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_index = '0;
    rsp_ready = 1'b1;
    pal_lock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'(0));
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_pal_index", 32'(pal_index), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_rsp_id", 32'(rsp_id), 32'(0));
    check("reset_rsp_rgb", 32'(rsp_rgb), 32'(0));
    reset_n = 1'b1;
    issue(4'b1111, 4'd0, 1'b1, 1'b0, 4'b0001, "first_grant");
    idle(3);

    // Single request: two-cycle latency.
    issue(4'b0100, 4'd5, 1'b1, 1'b0, 4'b0100, "single_grant");
    req_valid = '0;
    #1;
    check("single_pal_index", 32'(pal_index), 32'(5));
    check("single_rsp_early", 32'(rsp_valid), 32'(0));
    @(posedge clk);
    #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'(1));
    idle(2);

    // Round-robin with all requesters valid; back-to-back grants.
    for (int i = 0; i < 8; i++) issue(4'b1111, 4'd7, 1'b1, 1'b0, rr_seq[i], "rr_grant");
    idle(3);

    // Backpressure: two grants fill S1/S2, then no grant while held.
    issue(4'b0010, 4'd9, 1'b0, 1'b0, 4'b0010, "bp_grant0");
    issue(4'b0010, 4'd9, 1'b0, 1'b0, 4'b0010, "bp_grant1");
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      check("bp_rsp_rgb", 32'(rsp_rgb), 32'h0B93);
      check("bp_rsp_id", 32'(rsp_id), 32'(1));
      check("bp_pal_index", 32'(pal_index), 32'(9));
      issue(4'b0010, 4'd9, 1'b0, 1'b0, 4'b0000, "bp_no_grant");
    end
    issue('0, 4'd9, 1'b1, 1'b0, '0, "bp_release");
    idle(2);
    check("bp_busy_idle", 32'(busy), 32'(0));

    // Lock with two lookups in flight.
    issue(4'b1001, 4'd7, 1'b1, 1'b0, lock_seq[0], "lock_pre0");
    issue(4'b1001, 4'd7, 1'b1, 1'b0, lock_seq[1], "lock_pre1");
    check("lock_busy0", 32'(busy), 32'(1));
    issue(4'b1001, 4'd7, 1'b1, 1'b1, 4'b0000, "lock_blocked");
    check("lock_busy1", 32'(busy), 32'(1));
    issue(4'b1001, 4'd7, 1'b1, 1'b1, 4'b0000, "lock_blocked");
    check("lock_busy2", 32'(busy), 32'(0));
    issue(4'b1001, 4'd7, 1'b1, 1'b1, 4'b0000, "lock_blocked");
    issue(4'b1001, 4'd7, 1'b1, 1'b0, lock_seq[2], "lock_resume");
    idle(3);

    // Requesters 1 and 3 both valid continuously.
    for (int i = 0; i < 4; i++) issue(4'b1010, 4'd5, 1'b1, 1'b0, pair_seq[i], "pair_grant");
    idle(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    check("final_busy", 32'(busy), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
